mult_seq_param: RTL and testbench

Parametrised sequential shift-add multiplier; successor to the fixed 4-bit mult_32 datapath. Multiplies two WIDTH-bit operands over WIDTH iterations. Runtime unsigned or two's-complement signed mode. Rising-edge start, busy flag and one-cycle done pulse, for use under a controller FSM in the ASIC-flow test designs.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_sign_fix.sv | 12 +
 rtl/mult_seq_param.sv | 130 +++++++++++++
 tb/tb_mult_seq_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and a two's-complement magnitude helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAG_W = 32;

  // Operands narrower than MAG_W are sign-extended by the caller before use.
  function automatic logic [MAG_W-1:0] mag_abs(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational conditional two's-complement negate of a W-bit value.
module mult_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, WIDTH iterations, unsigned or signed.
// state | meaning
// IDLE  | waiting for a rising edge of init
// CALC  | one shift-add iteration per cycle, WIDTH cycles
// FIX   | apply result sign, load pp, pulse done
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] pp,
  output logic               done,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    pp_q, pp_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             init_q;

  logic             start;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    pp_fix;

  assign start = init & ~init_q & (state_q == IDLE);

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign abs_a = sgn ? WIDTH'(mag_abs(MAG_W'($signed(A)))) : A;
  assign abs_b = sgn ? WIDTH'(mag_abs(MAG_W'($signed(B)))) : B;

  mult_sign_fix #(.W(PW)) u_sign_fix (
    .val_i (acc_q),
    .neg_i (neg_q),
    .res_o (pp_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    pp_d    = pp_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mag_a_d = PW'(abs_a);
          mag_b_d = abs_b;
          // Zero operand forces a positive result so no -0 path exists.
          neg_d   = sgn & (A[WIDTH-1] ^ B[WIDTH-1]) & (|A) & (|B);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // mag_a_q is pre-shifted each cycle, equivalent to mag_a << counter.
        if (mag_b_q[0]) begin
          acc_d = acc_q + mag_a_q;
        end
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        pp_d    = pp_fix;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      pp_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      pp_q    <= pp_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      init_q  <= init;
    end
  end

  assign pp   = pp_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed and back-to-back checks of mult_seq_param at WIDTH=4 and WIDTH=16.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        init4, sgn4;
  logic [3:0]  a4, b4;
  logic [7:0]  pp4;
  logic        done4, busy4;
  logic        init16, sgn16;
  logic [15:0] a16, b16;
  logic [31:0] pp16;
  logic        done16, busy16;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .init (init4),
    .sgn  (sgn4),
    .A    (a4),
    .B    (b4),
    .pp   (pp4),
    .done (done4),
    .busy (busy4)
  );

  mult_seq_param #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .init (init16),
    .sgn  (sgn16),
    .A    (a16),
    .B    (b16),
    .pp   (pp16),
    .done (done16),
    .busy (busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one WIDTH=4 operation; lat is the edge index (E0 = start) at which done was seen, -1 if never.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b, output int lat);
    sgn4 = s; a4 = a; b4 = b; init4 = 1'b1;
    tick();
    init4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done4 === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    init16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) tick();
    vec++; if (pp4 !== 8'h00)  begin miss++; $display("FAIL reset_pp4: got %h want 00", pp4); end
    vec++; if (done4 !== 1'b0) begin miss++; $display("FAIL reset_done4: got %b want 0", done4); end
    vec++; if (busy4 !== 1'b0) begin miss++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    vec++; if (pp16 !== 32'h0) begin miss++; $display("FAIL reset_pp16: got %h want 0", pp16); end
    vec++; if (busy16 !== 1'b0) begin miss++; $display("FAIL reset_busy16: got %b want 0", busy16); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int nd = 0;
    int first = -1;
    logic busy_ok = 1'b1;
    sgn4 = 1'b0; a4 = 4'd3; b4 = 4'd5; init4 = 1'b1;
    tick();                            // E0
    if (busy4 !== 1'b1) busy_ok = 1'b0;
    tick();                            // E1, init still high
    if (busy4 !== 1'b1) busy_ok = 1'b0;
    init4 = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (done4 === 1'b1) begin
        nd++;
        if (first < 0) first = k;
      end
      if (k <= 5 && busy4 !== 1'b1) busy_ok = 1'b0;
      if (k >= 6 && busy4 !== 1'b0) busy_ok = 1'b0;
    end
    vec++; if (nd != 1)        begin miss++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    vec++; if (first != 5)     begin miss++; $display("FAIL basic_done_edge: got E%0d want E5", first); end
    vec++; if (pp4 !== 8'h0F)  begin miss++; $display("FAIL basic_pp: got %h want 0f", pp4); end
    vec++; if (!busy_ok)       begin miss++; $display("FAIL basic_busy_window: got mismatch want high E0..E5 only"); end
  endtask

  task automatic test_modes();
    int lat;
    op4(1'b0, 4'hF, 4'hF, lat);
    vec++; if (pp4 !== 8'hE1 || lat != 5) begin miss++; $display("FAIL uns_15x15: pp=%h lat=%0d want e1 5", pp4, lat); end
    op4(1'b1, 4'hD, 4'h5, lat);
    vec++; if (pp4 !== 8'hF1 || lat != 5) begin miss++; $display("FAIL sgn_m3x5: pp=%h lat=%0d want f1 5", pp4, lat); end
    op4(1'b0, 4'h8, 4'h8, lat);
    vec++; if (pp4 !== 8'h40 || lat != 5) begin miss++; $display("FAIL uns_8x8: pp=%h lat=%0d want 40 5", pp4, lat); end
    op4(1'b1, 4'hD, 4'hD, lat);
    vec++; if (pp4 !== 8'h09 || lat != 5) begin miss++; $display("FAIL sgn_m3xm3: pp=%h lat=%0d want 09 5", pp4, lat); end
  endtask

  task automatic test_extremes();
    int lat;
    op4(1'b1, 4'h8, 4'h8, lat);
    vec++; if (pp4 !== 8'h40 || lat != 5) begin miss++; $display("FAIL sgn_m8xm8: pp=%h lat=%0d want 40 5", pp4, lat); end
    op4(1'b1, 4'h8, 4'h7, lat);
    vec++; if (pp4 !== 8'hC8 || lat != 5) begin miss++; $display("FAIL sgn_m8x7: pp=%h lat=%0d want c8 5", pp4, lat); end
    op4(1'b1, 4'h0, 4'h9, lat);
    vec++; if (pp4 !== 8'h00 || lat != 5) begin miss++; $display("FAIL sgn_0xm7: pp=%h lat=%0d want 00 5", pp4, lat); end
    op4(1'b0, 4'hF, 4'h0, lat);
    vec++; if (pp4 !== 8'h00 || lat != 5) begin miss++; $display("FAIL uns_15x0: pp=%h lat=%0d want 00 5", pp4, lat); end
  endtask

  task automatic test_ignore_restart();
    int nd = 0;
    int first = -1;
    sgn4 = 1'b0; a4 = 4'd6; b4 = 4'd7; init4 = 1'b1;
    tick();                            // E0
    a4 = 4'd1; b4 = 4'd1; sgn4 = 1'b1; init4 = 1'b0;
    tick();                            // E1
    init4 = 1'b1;                      // rising edge seen at E2 while busy
    tick();                            // E2
    for (int k = 3; k <= 16; k++) begin
      tick();
      if (done4 === 1'b1) begin
        nd++;
        if (first < 0) first = k;
      end
    end
    init4 = 1'b0;
    tick();
    vec++; if (nd != 1 || first != 5) begin miss++; $display("FAIL ignore_done: count=%0d edge=%0d want 1 5", nd, first); end
    vec++; if (pp4 !== 8'h2A)         begin miss++; $display("FAIL ignore_pp: got %h want 2a", pp4); end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    sgn4 = 1'b0; a4 = 4'd5; b4 = 4'd3; init4 = 1'b1;
    tick();                            // E0
    init4 = 1'b0;
    tick();                            // E1
    tick();                            // E2
    rst = 1'b1;
    tick();                            // E3 under reset
    vec++; if (pp4 !== 8'h00)  begin miss++; $display("FAIL midrst_pp: got %h want 00", pp4); end
    vec++; if (done4 !== 1'b0) begin miss++; $display("FAIL midrst_done: got %b want 0", done4); end
    vec++; if (busy4 !== 1'b0) begin miss++; $display("FAIL midrst_busy: got %b want 0", busy4); end
    sgn4 = 1'b1; a4 = 4'hE; b4 = 4'h7; init4 = 1'b1;
    tick();                            // still in reset, init already high
    rst = 1'b0;
    tick();                            // first edge after reset: counts as a rising edge
    init4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done4 === 1'b1) begin
        lat = k;
        break;
      end
    end
    vec++; if (pp4 !== 8'hF2 || lat != 5) begin miss++; $display("FAIL postrst_m2x7: pp=%h lat=%0d want f2 5", pp4, lat); end
  endtask

  task automatic test_back_to_back();
    logic        s;
    logic [15:0] a, b;
    logic [31:0] expv;
    logic        early;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin s = 1'b1; a = 16'h8000; b = 16'h8000; end
        1: begin s = 1'b1; a = 16'h8000; b = 16'h7FFF; end
        2: begin s = 1'b0; a = 16'hFFFF; b = 16'hFFFF; end
        3: begin s = 1'b1; a = 16'h0000; b = 16'h8000; end
        4: begin s = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
        default: begin s = 1'($urandom); a = 16'($urandom); b = 16'($urandom); end
      endcase
      if (s) expv = 32'($signed(a)) * 32'($signed(b));
      else   expv = 32'(a) * 32'(b);
      sgn16 = s; a16 = a; b16 = b; init16 = 1'b1;
      tick();                          // start edge
      init16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~s;
      early = 1'b0;
      for (int k = 1; k <= 17; k++) begin
        tick();
        if (k < 17 && done16 === 1'b1) early = 1'b1;
      end
      vec++;
      if (done16 !== 1'b1 || pp16 !== expv || early) begin
        miss++;
        $display("FAIL b2b_%0d: s=%b a=%h b=%h pp=%h done=%b early=%b want pp=%h done=1 early=0",
                 i, s, a, b, pp16, done16, early, expv);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_extremes();
    test_ignore_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
